// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, test-bar colour table and a clog2 helper
// for the VGA timing core and its pixel-rate divider.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int NUM_BARS = 8;

  // Per-bar channel enables {R,G,B}; each set bit becomes a full-scale channel.
  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    logic [2:0] f;
    f = 3'b000;
    case (idx)
      3'd0: f = 3'b111;  // white
      3'd1: f = 3'b110;  // yellow
      3'd2: f = 3'b011;  // cyan
      3'd3: f = 3'b010;  // green
      3'd4: f = 3'b101;  // magenta
      3'd5: f = 3'b100;  // red
      3'd6: f = 3'b001;  // blue
      default: f = 3'b000;  // black
    endcase
    return f;
  endfunction

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate clock enable: one-clk pix_tick every CLK_DIV system clocks.
// Stays on the system clock; CLK_DIV==1 yields a constant-high enable.
module vga_pix_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pix_tick
);

  localparam int DW = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div_cnt;

  // With CLK_DIV==1 the counter never leaves 0, so the enable is always high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DW'(1);
    end
  end

  assign pix_tick = (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_core.sv
// VGA timing engine: H/V counters on the pixel enable, registered sync and blanked RGB.
// Define VGA_TEST_PATTERN_EN to add a test_mode input that substitutes 8 colour bars.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 10,
  parameter int   RGB_W    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RGB_W-1:0] rgb_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  output logic [CW-1:0]    coord_x,
  output logic [CW-1:0]    coord_y,
  output logic             active_area,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start,
  output logic             h_sync,
  output logic             v_sync,
  output logic [RGB_W-1:0] rgb
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_LO = H_ACTIVE + H_FP;
  localparam int H_SYNC_HI = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_LO = V_ACTIVE + V_FP;
  localparam int V_SYNC_HI = V_ACTIVE + V_FP + V_SYNC;

  logic [CW-1:0]    r_h_cnt;
  logic [CW-1:0]    r_v_cnt;
  logic             r_h_sync;
  logic             r_v_sync;
  logic [RGB_W-1:0] r_rgb;

  logic             w_pix_tick;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_active;
  logic             w_hs_on;
  logic             w_vs_on;
  logic [RGB_W-1:0] w_src_rgb;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk      (clk),
    .reset    (reset),
    .pix_tick (w_pix_tick)
  );

  assign w_h_last = (r_h_cnt == CW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == CW'(V_TOTAL - 1));
  assign w_active = (r_h_cnt < CW'(H_ACTIVE)) && (r_v_cnt < CW'(V_ACTIVE));
  assign w_hs_on  = (r_h_cnt >= CW'(H_SYNC_LO)) && (r_h_cnt < CW'(H_SYNC_HI));
  assign w_vs_on  = (r_v_cnt >= CW'(V_SYNC_LO)) && (r_v_cnt < CW'(V_SYNC_HI));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_tick) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + CW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CW'(1);
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / NUM_BARS;
  localparam int CH_W  = RGB_W / 3;

  logic [CW-1:0] w_bar_full;
  logic [2:0]    w_bar_idx;
  logic [2:0]    w_bar_rgb;

  // Counts past the last bar only occur while blanked; clamp to keep the index in range.
  assign w_bar_full = r_h_cnt / CW'(BAR_W);
  assign w_bar_idx  = (w_bar_full > CW'(NUM_BARS - 1)) ? 3'd7 : w_bar_full[2:0];
  assign w_bar_rgb  = bar_flags(w_bar_idx);
  assign w_src_rgb  = test_mode ? RGB_W'({{CH_W{w_bar_rgb[2]}}, {CH_W{w_bar_rgb[1]}},
                                          {CH_W{w_bar_rgb[0]}}})
                                : rgb_in;
`else
  assign w_src_rgb = rgb_in;
`endif

  // Output stage samples the pre-advance counters, so it trails coordinates by one pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_sync <= ~HS_POL;
      r_v_sync <= ~VS_POL;
      r_rgb    <= '0;
    end else if (w_pix_tick) begin
      r_h_sync <= w_hs_on ? HS_POL : ~HS_POL;
      r_v_sync <= w_vs_on ? VS_POL : ~VS_POL;
      r_rgb    <= w_active ? w_src_rgb : '0;
    end
  end

  assign coord_x     = r_h_cnt;
  assign coord_y     = r_v_cnt;
  assign active_area = w_active;
  assign pix_tick    = w_pix_tick;
  assign line_start  = w_pix_tick && (r_h_cnt == '0);
  assign frame_start = w_pix_tick && (r_h_cnt == '0) && (r_v_cnt == '0);
  assign h_sync      = r_h_sync;
  assign v_sync      = r_v_sync;
  assign rgb         = r_rgb;

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench for vga_timing_core: a CLK_DIV=4 reduced-timing instance (a)
// and a CLK_DIV=1 tiny-timing instance (b) sharing clock and reset.
module tb_vga_timing_core;

  // Instance a: 32 x 15 totals, frame = 480 pixel ticks = 1920 clocks.
  localparam int A_DIV = 4;
  localparam int A_HA = 16, A_HFP = 4, A_HS = 6, A_HBP = 6, A_HT = 32;
  localparam int A_VA = 8,  A_VFP = 2, A_VS = 2, A_VBP = 3, A_VT = 15;
  localparam int A_FRAME = A_HT * A_VT;
  // Instance b: 14 x 7 totals, frame = 98 clocks.
  localparam int B_HA = 8, B_HFP = 2, B_HS = 2, B_HBP = 2, B_HT = 14;
  localparam int B_VA = 4, B_VFP = 1, B_VS = 1, B_VBP = 1, B_VT = 7;
  localparam int B_FRAME = B_HT * B_VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] rgb_in_a, rgb_in_b, rgb_a, rgb_b;
  logic [9:0]  coord_x_a, coord_y_a, coord_x_b, coord_y_b;
  logic active_area_a, pix_tick_a, line_start_a, frame_start_a, h_sync_a, v_sync_a;
  logic active_area_b, pix_tick_b, line_start_b, frame_start_b, h_sync_b, v_sync_b;
`ifdef VGA_TEST_PATTERN_EN
  logic test_mode_a = 1'b0;
  logic test_mode_b = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  vga_timing_core #(
    .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(10), .RGB_W(12)
  ) dut_a (
    .clk(clk), .reset(reset), .rgb_in(rgb_in_a),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode_a),
`endif
    .coord_x(coord_x_a), .coord_y(coord_y_a), .active_area(active_area_a),
    .pix_tick(pix_tick_a), .line_start(line_start_a), .frame_start(frame_start_a),
    .h_sync(h_sync_a), .v_sync(v_sync_a), .rgb(rgb_a)
  );

  vga_timing_core #(
    .CLK_DIV(1), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(10), .RGB_W(12)
  ) dut_b (
    .clk(clk), .reset(reset), .rgb_in(rgb_in_b),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode_b),
`endif
    .coord_x(coord_x_b), .coord_y(coord_y_b), .active_area(active_area_b),
    .pix_tick(pix_tick_b), .line_start(line_start_b), .frame_start(frame_start_b),
    .h_sync(h_sync_b), .v_sync(v_sync_b), .rgb(rgb_b)
  );

  // Graphics stand-in: a nonzero colour derived from the pixel position.
  function automatic logic [11:0] pat(int h, int v);
    return 12'((h * 37 + v * 101) % 4095 + 1);
  endfunction

  // Active-low sync expectation for a counter value.
  function automatic logic sync_exp(int c, int act, int fp, int sw);
    return !((c >= act + fp) && (c < act + fp + sw));
  endfunction

  task automatic drive_rgb();
    int ta;
    ta = cyc / A_DIV;
    rgb_in_a = pat(ta % A_HT, (ta / A_HT) % A_VT);
    rgb_in_b = pat(cyc % B_HT, (cyc / B_HT) % B_VT);
  endtask

  task automatic step();
    @(posedge clk);
    cyc = cyc + 1;
    @(negedge clk);
    drive_rgb();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    drive_rgb();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    drive_rgb();
    @(negedge clk);
    n_vec++; if (coord_x_a !== 10'd0) begin n_err++; $display("FAIL reset_x_a got=%0d exp=0", coord_x_a); end
    n_vec++; if (coord_y_a !== 10'd0) begin n_err++; $display("FAIL reset_y_a got=%0d exp=0", coord_y_a); end
    n_vec++; if (pix_tick_a !== 1'b0) begin n_err++; $display("FAIL reset_tick_a got=%b exp=0", pix_tick_a); end
    n_vec++; if (frame_start_a !== 1'b0) begin n_err++; $display("FAIL reset_fs_a got=%b exp=0", frame_start_a); end
    n_vec++; if (h_sync_a !== 1'b1) begin n_err++; $display("FAIL reset_hs_a got=%b exp=1", h_sync_a); end
    n_vec++; if (v_sync_a !== 1'b1) begin n_err++; $display("FAIL reset_vs_a got=%b exp=1", v_sync_a); end
    n_vec++; if (rgb_a !== 12'h000) begin n_err++; $display("FAIL reset_rgb_a got=%h exp=000", rgb_a); end
    n_vec++; if (pix_tick_b !== 1'b1) begin n_err++; $display("FAIL reset_tick_b got=%b exp=1", pix_tick_b); end
    n_vec++; if (frame_start_b !== 1'b1) begin n_err++; $display("FAIL reset_fs_b got=%b exp=1", frame_start_b); end
    n_vec++; if (rgb_b !== 12'h000) begin n_err++; $display("FAIL reset_rgb_b got=%h exp=000", rgb_b); end
    $display("test_reset done: %0d miscompares so far", n_err);
  endtask

  // Divider cadence, strobes and coordinates over a frame and a bit.
  task automatic test_divider();
    int t, h, v;
    logic tk;
    do_reset();
    for (int k = 0; k < A_DIV * (A_FRAME + 2); k++) begin
      step();
      t = cyc / A_DIV;
      h = t % A_HT;
      v = (t / A_HT) % A_VT;
      tk = ((cyc % A_DIV) == A_DIV - 1);
      n_vec++; if (pix_tick_a !== tk) begin n_err++; $display("FAIL div_tick cyc=%0d got=%b exp=%b", cyc, pix_tick_a, tk); end
      n_vec++; if (coord_x_a !== 10'(h) || coord_y_a !== 10'(v)) begin
        n_err++; $display("FAIL div_coord cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", cyc, coord_x_a, coord_y_a, h, v); end
      n_vec++; if (active_area_a !== (h < A_HA && v < A_VA)) begin
        n_err++; $display("FAIL div_active cyc=%0d got=%b exp=%b", cyc, active_area_a, (h < A_HA && v < A_VA)); end
      n_vec++; if (line_start_a !== (tk && h == 0)) begin
        n_err++; $display("FAIL div_line cyc=%0d got=%b exp=%b", cyc, line_start_a, (tk && h == 0)); end
      n_vec++; if (frame_start_a !== (tk && t % A_FRAME == 0)) begin
        n_err++; $display("FAIL div_frame cyc=%0d got=%b exp=%b", cyc, frame_start_a, (tk && t % A_FRAME == 0)); end
    end
    $display("test_divider done: %0d miscompares so far", n_err);
  endtask

  // Sync outputs trail the counter they were computed from by one pixel.
  task automatic test_sync();
    int t, p;
    logic hs, vs;
    do_reset();
    for (int k = 0; k < A_DIV * (A_FRAME + 2); k++) begin
      step();
      t = cyc / A_DIV;
      p = t - 1;
      hs = (t >= 1) ? sync_exp(p % A_HT, A_HA, A_HFP, A_HS) : 1'b1;
      vs = (t >= 1) ? sync_exp((p / A_HT) % A_VT, A_VA, A_VFP, A_VS) : 1'b1;
      n_vec++; if (h_sync_a !== hs) begin n_err++; $display("FAIL hsync cyc=%0d got=%b exp=%b", cyc, h_sync_a, hs); end
      n_vec++; if (v_sync_a !== vs) begin n_err++; $display("FAIL vsync cyc=%0d got=%b exp=%b", cyc, v_sync_a, vs); end
    end
    $display("test_sync done: %0d miscompares so far", n_err);
  endtask

  task automatic test_rgb();
    int t, ph, pv;
    logic [11:0] e;
    do_reset();
    for (int k = 0; k < A_DIV * (A_FRAME + 2); k++) begin
      step();
      t = cyc / A_DIV;
      ph = (t - 1) % A_HT;
      pv = ((t - 1) / A_HT) % A_VT;
      e = (t >= 1 && ph < A_HA && pv < A_VA) ? pat(ph, pv) : 12'h000;
      n_vec++; if (rgb_a !== e) begin n_err++; $display("FAIL rgb cyc=%0d got=%h exp=%h", cyc, rgb_a, e); end
    end
    $display("test_rgb done: %0d miscompares so far", n_err);
  endtask

  // CLK_DIV=1: tick every clock, frame every 98 clocks, wrap at (13,6).
  task automatic test_small_timing();
    int h, v, ph, pv;
    logic hs, vs;
    logic [11:0] e;
    do_reset();
    for (int k = 0; k < 2 * B_FRAME + 3; k++) begin
      step();
      h = cyc % B_HT;
      v = (cyc / B_HT) % B_VT;
      ph = (cyc - 1) % B_HT;
      pv = ((cyc - 1) / B_HT) % B_VT;
      hs = sync_exp(ph, B_HA, B_HFP, B_HS);
      vs = sync_exp(pv, B_VA, B_VFP, B_VS);
      e = (ph < B_HA && pv < B_VA) ? pat(ph, pv) : 12'h000;
      n_vec++; if (pix_tick_b !== 1'b1) begin n_err++; $display("FAIL b_tick cyc=%0d got=%b exp=1", cyc, pix_tick_b); end
      n_vec++; if (coord_x_b !== 10'(h) || coord_y_b !== 10'(v)) begin
        n_err++; $display("FAIL b_coord cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", cyc, coord_x_b, coord_y_b, h, v); end
      n_vec++; if (frame_start_b !== (cyc % B_FRAME == 0)) begin
        n_err++; $display("FAIL b_frame cyc=%0d got=%b exp=%b", cyc, frame_start_b, (cyc % B_FRAME == 0)); end
      n_vec++; if (line_start_b !== (h == 0)) begin n_err++; $display("FAIL b_line cyc=%0d got=%b exp=%b", cyc, line_start_b, (h == 0)); end
      n_vec++; if (active_area_b !== (h < B_HA && v < B_VA)) begin
        n_err++; $display("FAIL b_active cyc=%0d got=%b exp=%b", cyc, active_area_b, (h < B_HA && v < B_VA)); end
      n_vec++; if (h_sync_b !== hs || v_sync_b !== vs) begin
        n_err++; $display("FAIL b_sync cyc=%0d got=%b%b exp=%b%b", cyc, h_sync_b, v_sync_b, hs, vs); end
      n_vec++; if (rgb_b !== e) begin n_err++; $display("FAIL b_rgb cyc=%0d got=%h exp=%h", cyc, rgb_b, e); end
      if (cyc % B_FRAME == B_FRAME - 1) begin
        n_vec++; if (coord_x_b !== 10'd13 || coord_y_b !== 10'd6) begin
          n_err++; $display("FAIL b_wrap cyc=%0d got=(%0d,%0d) exp=(13,6)", cyc, coord_x_b, coord_y_b); end
      end
    end
    $display("test_small_timing done: %0d miscompares so far", n_err);
  endtask

  // Run instance a to a hand-picked point, check it, then assert reset between edges.
  task automatic test_mid_reset(int target, int ex, int ey, logic ehs, logic evs, logic [11:0] ergb);
    do_reset();
    while (cyc < target) step();
    n_vec++; if (coord_x_a !== 10'(ex) || coord_y_a !== 10'(ey)) begin
      n_err++; $display("FAIL mid_pre_coord got=(%0d,%0d) exp=(%0d,%0d)", coord_x_a, coord_y_a, ex, ey); end
    n_vec++; if (h_sync_a !== ehs || v_sync_a !== evs || rgb_a !== ergb) begin
      n_err++; $display("FAIL mid_pre_out got=%b%b/%h exp=%b%b/%h", h_sync_a, v_sync_a, rgb_a, ehs, evs, ergb); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (coord_x_a !== 10'd0 || coord_y_a !== 10'd0) begin
      n_err++; $display("FAIL mid_async_coord got=(%0d,%0d) exp=(0,0)", coord_x_a, coord_y_a); end
    n_vec++; if (h_sync_a !== 1'b1 || v_sync_a !== 1'b1 || rgb_a !== 12'h000) begin
      n_err++; $display("FAIL mid_async_out got=%b%b/%h exp=11/000", h_sync_a, v_sync_a, rgb_a); end
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    drive_rgb();
    repeat (3) step();
    n_vec++; if (frame_start_a !== 1'b1 || coord_x_a !== 10'd0 || coord_y_a !== 10'd0) begin
      n_err++; $display("FAIL mid_restart got=%b@(%0d,%0d) exp=1@(0,0)", frame_start_a, coord_x_a, coord_y_a); end
    step();
    n_vec++; if (coord_x_a !== 10'd1 || rgb_a !== pat(0, 0)) begin
      n_err++; $display("FAIL mid_resume got=%0d/%h exp=1/%h", coord_x_a, rgb_a, pat(0, 0)); end
    $display("test_mid_reset target=%0d done: %0d miscompares so far", target, n_err);
  endtask

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [11:0] bar_exp(int idx);
    case (idx)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  task automatic test_pattern();
    int t, p;
    logic [11:0] e;
    do_reset();
    test_mode_a = 1'b1;
    for (int k = 0; k < A_DIV * (A_HT + 1); k++) begin
      step();
      t = cyc / A_DIV;
      if (t >= 1) begin
        p = t - 1;
        e = (p < A_HA) ? bar_exp(p / (A_HA / 8)) : 12'h000;
        n_vec++; if (rgb_a !== e) begin n_err++; $display("FAIL bars cyc=%0d x=%0d got=%h exp=%h", cyc, p, rgb_a, e); end
      end
    end
    test_mode_a = 1'b0;
    $display("test_pattern done: %0d miscompares so far", n_err);
  endtask
`endif

  initial begin
    rgb_in_a = 12'h000;
    rgb_in_b = 12'h000;
    test_reset();
    test_divider();
    test_sync();
    test_rgb();
    test_small_timing();
    // Pixel (22,10): inside both sync pulses of instance a.
    test_mid_reset(343 * A_DIV, 23, 10, 1'b0, 1'b0, 12'h000);
    // Pixel (5,3): visible, so the registered colour is nonzero before reset.
    test_mid_reset(102 * A_DIV, 6, 3, 1'b1, 1'b1, pat(5, 3));
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
